// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box, GF(2^8) helpers, round-count and FSM encoding
// for the iterative encryptor and its round datapath.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINISH
    } aes_state_e;

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    // Successive Rcon values are successive doublings in GF(2^8).
    function automatic logic [7:0] rcon_next(input logic [7:0] rc);
        return xtime(rc);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5; 8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0; 8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc; 8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a; 8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0; 8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b; 8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85; 8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5; 8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17; 8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88; 8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c; 8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9; 8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6; 8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e; 8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94; 8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68; 8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_iter_encryptor_if.sv
// Start/busy/done handshake plus block and key buses of the iterative encryptor.
interface aes_iter_encryptor_if #(
    parameter int KEY_BITS = 128
);
    logic                start;
    logic [127:0]        text;
    logic [KEY_BITS-1:0] key;
    logic                busy;
    logic                done;
    logic [127:0]        ciphertext;

    modport master (output start, text, key, input busy, done, ciphertext);
    modport slave  (input start, text, key, output busy, done, ciphertext);
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when
// last_i) and AddRoundKey. Byte 0 of the state sits in bits [127:120].
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {mul2(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ mul2(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ mul2(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ mul2(a3)};
    endfunction

    logic [127:0] sr;
    logic [127:0] mc;

    // Byte 4c+r is row r of column c; row r rotates left by r columns.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sbox(state_i[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
        end
    end

    assign state_o = (last_i ? sr : mc) ^ rkey_i;

endmodule

// File: rtl/aes_iter_encryptor.sv
// Iterative AES-128/256 encryptor: one round per clock with the round key
// expanded on the fly alongside the datapath.
module aes_iter_encryptor
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_iter_encryptor_if.slave  bus
);

    localparam logic [3:0] NR = 4'(nr_of(KEY_BITS));

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_encryptor: KEY_BITS must be 128 or 256");
    end

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Chains the four words of the next chunk off the chunk Nk words back.
    function automatic logic [127:0] expand(input logic [127:0] p, input logic [31:0] t);
        logic [31:0] w0, w1, w2, w3;
        w0 = p[127:96] ^ t;
        w1 = p[95:64]  ^ w0;
        w2 = p[63:32]  ^ w1;
        w3 = p[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    aes_state_e   fsm_q,   fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] kcur_q,  kcur_d;
    logic [127:0] kprev_q, kprev_d;
    logic [127:0] ct_q,    ct_d;
    logic [7:0]   rcon_q,  rcon_d;
    logic [3:0]   rnd_q,   rnd_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;

    logic [127:0] rkey, round_out;
    logic [127:0] kcur_init, kprev_init, kcur_step, kprev_step;
    logic [7:0]   rcon_step;
    logic         last_rnd;

    assign last_rnd = (rnd_q == NR);

    if (KEY_BITS == 256) begin : g_ks256
        logic         even_r;
        logic [31:0]  temp;
        logic [127:0] chunk;
        assign even_r = ~rnd_q[0];
        assign temp   = even_r ? (sub_word(rot_word(kcur_q[31:0])) ^ {rcon_q, 24'h0})
                               : sub_word(kcur_q[31:0]);
        assign chunk  = expand(kprev_q, temp);
        // Round 1 consumes the second key half as-is; the window only slides from round 2.
        assign rkey       = (rnd_q == 4'd1) ? kcur_q  : chunk;
        assign kcur_step  = (rnd_q == 4'd1) ? kcur_q  : chunk;
        assign kprev_step = (rnd_q == 4'd1) ? kprev_q : kcur_q;
        assign rcon_step  = even_r ? rcon_next(rcon_q) : rcon_q;
        assign kcur_init  = bus.key[127:0];
        assign kprev_init = bus.key[255:128];
    end else begin : g_ks128
        assign rkey       = expand(kcur_q, sub_word(rot_word(kcur_q[31:0])) ^ {rcon_q, 24'h0});
        assign kcur_step  = rkey;
        assign kprev_step = kprev_q;
        assign rcon_step  = rcon_next(rcon_q);
        assign kcur_init  = bus.key[127:0];
        assign kprev_init = '0;
    end

    aes_round u_round (
        .state_i (state_q),
        .rkey_i  (rkey),
        .last_i  (last_rnd),
        .state_o (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        kcur_d  = kcur_q;
        kprev_d = kprev_q;
        rcon_d  = rcon_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ct_d    = ct_q;
        case (fsm_q)
            ST_IDLE, ST_FINISH: begin
                fsm_d = ST_IDLE;
                if (bus.start) begin
                    fsm_d   = ST_LOAD;
                    state_d = bus.text ^ bus.key[KEY_BITS-1 -: 128];
                    kcur_d  = kcur_init;
                    kprev_d = kprev_init;
                    rcon_d  = 8'h01;
                    rnd_d   = 4'd1;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: fsm_d = ST_ROUND;
            ST_ROUND: begin
                state_d = round_out;
                kcur_d  = kcur_step;
                kprev_d = kprev_step;
                rcon_d  = rcon_step;
                rnd_d   = rnd_q + 4'd1;
                if (last_rnd) begin
                    fsm_d  = ST_FINISH;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    ct_d   = round_out;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            kcur_q  <= '0;
            kprev_q <= '0;
            ct_q    <= '0;
            rcon_q  <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            kcur_q  <= kcur_d;
            kprev_q <= kprev_d;
            ct_q    <= ct_d;
            rcon_q  <= rcon_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ciphertext = ct_q;

endmodule

// File: tb/tb_aes_iter_encryptor.sv
// Bench for aes_iter_encryptor: AES-128 and AES-256 instances against FIPS-197
// vectors and a GF(2^8)-arithmetic reference cipher.
module tb_aes_iter_encryptor;

  bit   clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes_iter_encryptor_if #(.KEY_BITS(128)) bus128 ();
  aes_iter_encryptor_if #(.KEY_BITS(256)) bus256 ();

  aes_iter_encryptor #(.KEY_BITS(128)) u_dut128 (.clk(clk), .rst_n(rst_n), .bus(bus128));
  aes_iter_encryptor #(.KEY_BITS(256)) u_dut256 (.clk(clk), .rst_n(rst_n), .bus(bus256));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse (a^254) then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(a));
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; AES-128 uses only the upper half.
  function automatic logic [127:0] aes_ref(input bit is256, input logic [255:0] k, input logic [127:0] pt);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc, acc;
    logic [7:0]  s [4][4];
    logic [7:0]  u [4][4];
    logic [7:0]  mcm [4];
    logic [127:0] out;
    int nk, nr;
    nk = is256 ? 8 : 4; nr = nk + 6; rc = 8'h01;
    mcm[0] = 8'h02; mcm[1] = 8'h03; mcm[2] = 8'h01; mcm[3] = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          u[r][c] = sb[s[r][(c+r)%4]];
      s = u;
      if (rnd != nr) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gf_mul(mcm[(j-r+4)%4], s[j][c]);
            u[r][c] = acc;
          end
        s = u;
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] ^= w[4*rnd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        out[127-8*(4*c+r) -: 8] = s[r][c];
    return out;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd_key(input bit is256);
    logic [255:0] k;
    k = {rnd128(), rnd128()};
    if (!is256) k[127:0] = '0;
    return k;
  endfunction

  task automatic drive(input bit is256, input logic st, input logic [127:0] tx, input logic [255:0] k);
    if (is256) begin bus256.start = st; bus256.text = tx; bus256.key = k; end
    else begin bus128.start = st; bus128.text = tx; bus128.key = k[255:128]; end
  endtask

  function automatic logic get_busy(input bit is256);
    return is256 ? bus256.busy : bus128.busy;
  endfunction
  function automatic logic get_done(input bit is256);
    return is256 ? bus256.done : bus128.done;
  endfunction
  function automatic logic [127:0] get_ct(input bit is256);
    return is256 ? bus256.ciphertext : bus128.ciphertext;
  endfunction

  // One block: checks latency, busy profile, single done pulse and result.
  task automatic run_block(input bit is256, input logic [255:0] k, input logic [127:0] tx,
                           input string tag, input logic [127:0] exp);
    int p, lat, ndone, busy_err;
    logic [127:0] ct;
    p = is256 ? 16 : 12; lat = 0; ndone = 0; busy_err = 0; ct = '0;
    drive(is256, 1'b1, tx, k);
    for (int e = 1; e <= p + 4; e++) begin
      tick();
      if (e == 1) drive(is256, 1'b0, rnd128(), rnd_key(is256));
      if (get_busy(is256) !== (e < p)) busy_err++;
      if (get_done(is256) === 1'b1) begin
        ndone++;
        if (lat == 0) begin lat = e; ct = get_ct(is256); end
      end
    end
    chk({tag, "_lat"},   128'(lat), 128'(p));
    chk({tag, "_busy"},  128'(busy_err), 128'd0);
    chk({tag, "_ndone"}, 128'(ndone), 128'd1);
    chk({tag, "_ct"},    ct, exp);
  endtask

  // start held high throughout; text/key move right after each accept edge.
  task automatic b2b(input bit is256);
    int p;
    int dn_e [$];
    logic [127:0] dn_ct [$];
    logic [255:0] ka, kb, kc;
    logic [127:0] ta, tb, tc;
    logic [127:0] ex [3];
    p = is256 ? 16 : 12;
    ka = rnd_key(is256); kb = rnd_key(is256); kc = rnd_key(is256);
    ta = rnd128(); tb = rnd128(); tc = rnd128();
    ex[0] = aes_ref(is256, ka, ta);
    ex[1] = aes_ref(is256, kb, tb);
    ex[2] = aes_ref(is256, kc, tc);
    drive(is256, 1'b1, ta, ka);
    for (int e = 1; e <= 3*p + 8; e++) begin
      tick();
      if (get_done(is256) === 1'b1) begin dn_e.push_back(e); dn_ct.push_back(get_ct(is256)); end
      if (e == 1)            drive(is256, 1'b1, tb, kb);
      else if (e == p + 1)   drive(is256, 1'b1, tc, kc);
      else if (e == 2*p + 1) drive(is256, 1'b0, rnd128(), rnd_key(is256));
    end
    chk(is256 ? "b2b256_ndone" : "b2b128_ndone", 128'(dn_e.size()), 128'd3);
    for (int i = 0; i < 3 && i < dn_e.size(); i++) begin
      chk($sformatf("b2b%0d_edge%0d", is256 ? 256 : 128, i), 128'(dn_e[i]), 128'((i+1)*p));
      chk($sformatf("b2b%0d_ct%0d", is256 ? 256 : 128, i), dn_ct[i], ex[i]);
    end
  endtask

  // ---------------- main sequence ----------------
  localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] TXT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] TXT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] acc;
    logic [255:0] k;
    logic [127:0] tx;
    int ndone;
    build_sbox();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    repeat (3) tick();
    chk("rst_busy", 128'({bus128.busy, bus256.busy}), 128'd0);
    chk("rst_done", 128'({bus128.done, bus256.done}), 128'd0);
    chk("rst_ct",   bus128.ciphertext | bus256.ciphertext, 128'd0);
    rst_n = 1'b1;

    acc = '0;
    for (int i = 0; i < 100; i++) begin
      tick();
      acc |= bus128.ciphertext | bus256.ciphertext
           | 128'({bus128.busy, bus128.done, bus256.busy, bus256.done});
    end
    chk("idle_quiet", acc, 128'd0);

    run_block(1'b0, KEY_B,  TXT_B, "kat_b",  CT_B);
    run_block(1'b0, KEY_C1, TXT_C, "kat_c1", CT_C1);
    run_block(1'b1, KEY_C3, TXT_C, "kat_c3", CT_C3);

    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 2; w++) begin
        k = rnd_key(w[0]); tx = rnd128();
        run_block(w[0], k, tx, $sformatf("rand%0d_%0d", w ? 256 : 128, i), aes_ref(w[0], k, tx));
      end
    end

    b2b(1'b0);
    b2b(1'b1);

    // Abort an AES-128 block on its fifth round edge (edge 7).
    drive(1'b0, 1'b1, TXT_B, KEY_B);
    tick();
    drive(1'b0, 1'b0, TXT_B, KEY_B);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 128'(bus128.busy), 128'd0);
    chk("abort_done", 128'(bus128.done), 128'd0);
    chk("abort_ct",   bus128.ciphertext, 128'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus128.done === 1'b1 || bus128.busy === 1'b1) ndone++;
    end
    chk("abort_silent", 128'(ndone), 128'd0);
    run_block(1'b0, KEY_B, TXT_B, "after_abort", CT_B);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
